// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared types and width defaults for the memory port arbiter
package riscv_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - fetch/data winner selection with a saturating data-burst counter
module mem_arb_pick
  import riscv_mem_pkg::*;
#(
  parameter int MAX_DATA_BURST = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   if_req,
  input  logic   d_req,
  input  logic   gnt,
  output owner_t winner
);

  localparam logic [3:0] BURST_MAX = 4'(MAX_DATA_BURST);

  logic [3:0] burst_cnt;

  // Data wins unless fetch is waiting and data has already used its burst allowance
  always_comb begin
    winner = OWN_FETCH;
    if (d_req && !(if_req && (burst_cnt == BURST_MAX))) begin
      winner = OWN_DATA;
    end
  end

  // Count data grants taken while fetch waits; any other grant resets the run
  always_ff @(posedge clk) begin
    if (!reset) begin
      burst_cnt <= 4'd0;
    end else if (gnt) begin
      if ((winner == OWN_DATA) && if_req) begin
        if (burst_cnt != BURST_MAX) begin
          burst_cnt <= burst_cnt + 4'd1;
        end
      end else begin
        burst_cnt <= 4'd0;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory shared between fetch and load/store paths
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int MEM_LAT        = 1,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int         STRB_W   = DATA_W / 8;
  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

  arb_state_t        state;
  owner_t            owner;
  owner_t            winner;
  logic [2:0]        lat_cnt;
  logic              store_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              grant;
  logic              done;

  // Reset overrides everything, so a grant never coincides with reset low
  assign grant = reset && (state == ARB_IDLE) && (if_req || d_req);
  assign done  = reset && (state == ARB_BUSY) && (lat_cnt == 3'd0);

  mem_arb_pick #(
    .MAX_DATA_BURST(MAX_DATA_BURST)
  ) u_pick (
    .clk   (clk),
    .reset (reset),
    .if_req(if_req),
    .d_req (d_req),
    .gnt   (grant),
    .winner(winner)
  );

  // Grant and memory strobe come out in the request cycle; the winner's fields are steered to memory
  always_comb begin
    if_gnt    = grant && (winner == OWN_FETCH);
    d_gnt     = grant && (winner == OWN_DATA);
    mem_en    = grant;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = {STRB_W{1'b0}};
    if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_wstrb = d_wstrb;
    end else if (if_gnt) begin
      mem_addr = if_addr;
    end
  end

  // Response side: memory data is forwarded in the completion cycle and held afterwards
  always_comb begin
    if_rvalid = done && (owner == OWN_FETCH);
    d_rvalid  = done && (owner == OWN_DATA);
    busy      = reset && (state == ARB_BUSY);
    if_rdata  = reset ? if_rdata_q : '0;
    d_rdata   = reset ? d_rdata_q : '0;
    if (if_rvalid) begin
      if_rdata = mem_rdata;
    end
    if (d_rvalid) begin
      d_rdata = store_q ? '0 : mem_rdata;
    end
  end

  // Transaction FSM: latch owner on grant, count down the memory latency, capture returned data
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ARB_IDLE;
      owner      <= OWN_FETCH;
      lat_cnt    <= 3'd0;
      store_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant) begin
            state   <= ARB_BUSY;
            owner   <= winner;
            lat_cnt <= LAT_INIT;
            store_q <= d_gnt && d_we;
          end
        end
        ARB_BUSY: begin
          if (lat_cnt != 3'd0) begin
            lat_cnt <= lat_cnt - 3'd1;
          end else begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
      if (if_rvalid) begin
        if_rdata_q <= mem_rdata;
      end
      if (d_rvalid) begin
        d_rdata_q <= store_q ? '0 : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter at latencies 1 and 3
module tb_mem_port_arbiter;

  typedef struct {
    bit          is_data;
    logic [31:0] data;
    int          cyc;
  } sb_t;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  sb_t         exp_q[$];
  sb_t         e;
  bit          sel = 1'b0;
  logic [31:0] exp_if_data = 32'h0;
  logic [31:0] exp_d_data = 32'h0;

  logic        rst_a, rst_b;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_wstrb;

  logic        a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid, a_mem_en, a_mem_we, a_busy;
  logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_mem_wstrb;
  logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_wstrb;

  logic [31:0] mem [0:63];
  logic [31:0] pipe_a;
  logic [31:0] pipe_b [0:2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_DATA_BURST(4)) dut_a (
    .clk(clk), .reset(rst_a),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt), .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_wstrb(a_mem_wstrb), .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .MAX_DATA_BURST(4)) dut_b (
    .clk(clk), .reset(rst_b),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_wstrb(b_mem_wstrb), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  wire        cur_if_gnt    = sel ? b_if_gnt : a_if_gnt;
  wire        cur_d_gnt     = sel ? b_d_gnt : a_d_gnt;
  wire        cur_if_rvalid = sel ? b_if_rvalid : a_if_rvalid;
  wire        cur_d_rvalid  = sel ? b_d_rvalid : a_d_rvalid;
  wire [31:0] cur_if_rdata  = sel ? b_if_rdata : a_if_rdata;
  wire [31:0] cur_d_rdata   = sel ? b_d_rdata : a_d_rdata;
  wire        cur_mem_en    = sel ? b_mem_en : a_mem_en;
  wire        cur_mem_we    = sel ? b_mem_we : a_mem_we;
  wire [31:0] cur_mem_addr  = sel ? b_mem_addr : a_mem_addr;
  wire [31:0] cur_mem_wdata = sel ? b_mem_wdata : a_mem_wdata;
  wire [3:0]  cur_mem_wstrb = sel ? b_mem_wstrb : a_mem_wstrb;
  wire        cur_busy      = sel ? b_busy : a_busy;

  assign a_mem_rdata = pipe_a;
  assign b_mem_rdata = pipe_b[2];

  // memory model: latency-1 port for dut_a, latency-3 port for dut_b, byte-strobed writes
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int k = 0; k < 64; k++) mem[k] <= 32'h0;
      mem[4]  <= 32'h00500093;
      mem[17] <= 32'h12345678;
    end
    if (a_mem_en) begin
      pipe_a <= mem[a_mem_addr[7:2]];
      if (a_mem_we)
        for (int k = 0; k < 4; k++)
          if (a_mem_wstrb[k]) mem[a_mem_addr[7:2]][8*k +: 8] <= a_mem_wdata[8*k +: 8];
    end
    if (b_mem_en) begin
      pipe_b[0] <= mem[b_mem_addr[7:2]];
      if (b_mem_we)
        for (int k = 0; k < 4; k++)
          if (b_mem_wstrb[k]) mem[b_mem_addr[7:2]][8*k +: 8] <= b_mem_wdata[8*k +: 8];
    end
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // monitor: every rvalid pops one expectation; no grant may appear while busy
  always @(negedge clk) begin
    if (cur_busy) check("no_gnt_while_busy", {62'b0, cur_if_gnt, cur_d_gnt}, 64'd0);
    if (cur_if_rvalid || cur_d_rvalid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rvalid: got if=%0b d=%0b, expected none (cycle %0d)",
                 cur_if_rvalid, cur_d_rvalid, cyc);
      end else begin
        e = exp_q.pop_front();
        check("rvalid_owner", {cur_if_rvalid, cur_d_rvalid}, e.is_data ? 64'd1 : 64'd2);
        check("rvalid_cycle", cyc, e.cyc);
        check("rdata", e.is_data ? cur_d_rdata : cur_if_rdata, e.data);
      end
    end
  end

  // wait for each grant in 'order', checking who, when, and what reaches the memory port
  task automatic watch(input string order, input int lat, input bit hold);
    int t0;
    t0 = cyc;
    for (int i = 0; i < order.len(); i++) begin
      int  waited;
      bit  got;
      byte who;
      waited = 0;
      got = 0;
      while (!got && waited < 40) begin
        @(negedge clk);
        if (cur_if_gnt || cur_d_gnt) got = 1;
        else begin
          check("wait_busy", cur_busy, 1);
          waited++;
        end
      end
      if (!got) begin
        vectors++;
        miscompares++;
        $display("FAIL grant_timeout: got no grant, expected %s (cycle %0d)", order, cyc);
        if_req = 0;
        d_req = 0;
        return;
      end
      who = cur_d_gnt ? "D" : "F";
      check("grant_who", who, order[i]);
      check("grant_cycle", cyc, t0 + i * (lat + 1));
      check("grant_one_hot", cur_if_gnt & cur_d_gnt, 0);
      check("grant_mem_en", cur_mem_en, 1);
      if (who == "D") begin
        check("grant_d_addr", cur_mem_addr, d_addr);
        check("grant_d_we", cur_mem_we, d_we);
        if (d_we) begin
          check("grant_wdata", cur_mem_wdata, d_wdata);
          check("grant_wstrb", cur_mem_wstrb, d_wstrb);
        end
        exp_q.push_back('{is_data: 1'b1, data: d_we ? 32'h0 : exp_d_data, cyc: cyc + lat});
      end else begin
        check("grant_if_addr", cur_mem_addr, if_addr);
        check("grant_if_we_strb", {cur_mem_we, cur_mem_wstrb}, 0);
        exp_q.push_back('{is_data: 1'b0, data: exp_if_data, cyc: cyc + lat});
      end
      @(posedge clk); #1;
      if (i == order.len() - 1) begin
        if_req = 0;
        d_req = 0;
      end else if (!hold) begin
        if (who == "D") d_req = 0;
        else if_req = 0;
      end
    end
  endtask

  task automatic settle();
    int n;
    n = 0;
    @(negedge clk);
    while (cur_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("settle_idle", cur_busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic data_req(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] strb, input logic [31:0] rd_exp);
    d_we = we;
    d_addr = addr;
    d_wdata = wd;
    d_wstrb = strb;
    exp_d_data = rd_exp;
    d_req = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 0; rst_b = 0;
    if_req = 1; d_req = 1; d_we = 0;
    if_addr = 32'h10; d_addr = 32'h40; d_wdata = 0; d_wstrb = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs_a", {a_if_gnt, a_d_gnt, a_mem_en, a_busy, a_if_rvalid, a_d_rvalid,
                           |a_if_rdata, |a_d_rdata, |a_mem_addr}, 0);
    check("reset_outs_b", {b_if_gnt, b_d_gnt, b_mem_en, b_busy, b_if_rvalid, b_d_rvalid,
                           |b_if_rdata, |b_d_rdata, |b_mem_addr}, 0);
    @(posedge clk); #1;
    if_req = 0; d_req = 0;
    rst_a = 1;
    @(posedge clk); #1;

    // 1: fetch alone, latency 1
    exp_if_data = 32'h00500093;
    if_addr = 32'h10; if_req = 1;
    watch("F", 1, 0);
    @(negedge clk);
    check("t1_busy_c1", cur_busy, 1);
    @(negedge clk);
    check("t1_idle_c2", {cur_busy, cur_if_rvalid, cur_mem_en, cur_if_gnt}, 0);
    @(posedge clk); #1;

    // 2: full store, load back, partial store, load back
    data_req(1, 32'h40, 32'hDEADBEEF, 4'hF, 32'h0);
    watch("D", 1, 0); settle();
    data_req(0, 32'h40, 32'h0, 4'h0, 32'hDEADBEEF);
    watch("D", 1, 0); settle();
    data_req(1, 32'h40, 32'h11112222, 4'h3, 32'h0);
    watch("D", 1, 0); settle();
    data_req(0, 32'h40, 32'h0, 4'h0, 32'hDEAD2222);
    watch("D", 1, 0); settle();
    check("rdata_hold_d", cur_d_rdata, 32'hDEAD2222);
    check("rdata_hold_if", cur_if_rdata, 32'h00500093);

    // 3: simultaneous requests, data first then fetch
    data_req(0, 32'h40, 32'h0, 4'h0, 32'hDEAD2222);
    if_addr = 32'h10; if_req = 1;
    watch("DF", 1, 0); settle();

    // 4: both held, burst limit lets fetch in every fifth grant
    data_req(0, 32'h44, 32'h0, 4'h0, 32'h12345678);
    if_addr = 32'h10; if_req = 1;
    watch("DDDDFDDDDF", 1, 1); settle();

    // 5: latency 3 with data held: grants 4 cycles apart, busy in between
    rst_a = 0; sel = 1; rst_b = 1;
    @(posedge clk); #1;
    data_req(0, 32'h44, 32'h0, 4'h0, 32'h12345678);
    watch("DD", 3, 1); settle();

    // 6: reset one cycle after a data grant aborts it without rvalid
    data_req(0, 32'h44, 32'h0, 4'h0, 32'h12345678);
    @(negedge clk);
    check("t6_d_gnt", cur_d_gnt, 1);
    @(posedge clk); #1;
    d_req = 0; rst_b = 0;
    @(negedge clk);
    check("t6_reset_outs", {cur_if_gnt, cur_d_gnt, cur_mem_en, cur_busy, cur_if_rvalid,
                            cur_d_rvalid, |cur_d_rdata}, 0);
    @(posedge clk); #1;
    rst_b = 1;
    @(negedge clk);
    check("t6_after_reset", {cur_busy, cur_d_rvalid, cur_if_rvalid}, 0);
    repeat (6) @(posedge clk);
    #1;
    exp_if_data = 32'h00500093;
    if_addr = 32'h10; if_req = 1;
    watch("F", 3, 0); settle();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port synchronous memory between the processor's instruction-fetch path and its load/store path. It accepts one request at a time and routes the read data or write completion back to the requester that owns it. Data accesses have priority, and a burst limit stops fetch from starving. It sits between the processor top and the unified instruction/data memory, and the processor stalls on the grant and valid signals.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data width in bits (multiple of 8)
MEM_LAT, 1, memory read latency in cycles from mem_en to mem_rdata valid; legal range 1..7
MAX_DATA_BURST, 4, consecutive data grants allowed while fetch is waiting; legal range 1..15

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
if_req  in  1  fetch request; held high until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  one-cycle fetch grant
if_rvalid  out  1  one-cycle pulse; if_rdata valid
if_rdata  out  DATA_W  fetch data
d_req  in  1  data request; held high until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_wstrb  in  DATA_W/8  byte enables for stores
d_gnt  out  1  one-cycle data grant
d_rvalid  out  1  one-cycle pulse; load data valid, or store complete
d_rdata  out  DATA_W  load data; 0 for stores
mem_en  out  1  memory access strobe (one cycle)
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wstrb  out  DATA_W/8  memory byte enables
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
busy  out  1  a transaction is in flight

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE, owner=FETCH, burst_cnt=0, lat_cnt=0.
  - All outputs are 0.
  - An in-flight transaction is discarded; no rvalid is produced for it after reset.
- Only one transaction is outstanding at any time; there is no pipelining.
- FSM states: IDLE and BUSY.
- IDLE:
  - If no request is present: stay in IDLE with all grants and strobes at 0.
  - If any request is present: in the same cycle assert exactly one gnt and mem_en=1, and drive mem_we, mem_addr, mem_wdata and mem_wstrb from the winner.
  - For a fetch winner: mem_we=0, mem_wstrb=0.
  - Next state: BUSY, with lat_cnt=MEM_LAT-1 and owner latched.
- Arbitration:
  - Only d_req: data wins. Only if_req: fetch wins.
  - Both present: data wins unless burst_cnt==MAX_DATA_BURST, in which case fetch wins.
  - burst_cnt increments on each data grant made while if_req=1, saturating at MAX_DATA_BURST.
  - burst_cnt clears to 0 on any fetch grant, and on any data grant made while if_req=0.
- BUSY:
  - If lat_cnt>0: decrement lat_cnt.
  - If lat_cnt==0: pulse the owner's rvalid for one cycle and register the owner's rdata. For loads and fetches rdata=mem_rdata; for stores d_rdata=0. The next state is IDLE.
  - The timing is the same for stores and loads, so store completion comes MEM_LAT cycles after the grant.
  - busy=1 throughout BUSY.
- Latency and throughput:
  - rvalid is asserted in cycle G+MEM_LAT, where G is the grant cycle.
  - The next grant is possible at G+MEM_LAT+1, giving a peak of one access per MEM_LAT+1 cycles.
- rdata holds its last value between pulses. The non-owner's rvalid stays 0.
- Request protocol:
  - A request dropped before its gnt is legal and is ignored; nothing is latched.
  - Address and data are sampled only in the grant cycle, so requesters may change them afterwards.
  - Requests that arrive while BUSY wait; gnt is never asserted in BUSY.
- Simultaneous reset and grant: reset wins and no grant is issued.

Decomposition:
- Package riscv_mem_pkg holds:
  - ADDR_W and DATA_W defaults
  - owner_t enum {OWN_FETCH, OWN_DATA}
  - arb_state_t enum {ARB_IDLE, ARB_BUSY}
- One sub-module, mem_arb_pick: the winner selection plus the saturating burst_cnt register. Inputs are if_req, d_req and a grant strobe; the output is the winner.
- The FSM, latency counter and muxes stay in the top.

Test Plan:
1. Fetch only, MEM_LAT=1: if_req with if_addr=0x10, mem word 0x00500093.
   - if_gnt and mem_en in cycle 0; if_rvalid=1 and if_rdata=0x00500093 in cycle 1; idle in cycle 2.
2. Store then load:
   - Store: d_we=1, addr 0x40, wdata 0xDEADBEEF, wstrb 0xF. d_rvalid=1 and d_rdata=0 after MEM_LAT cycles.
   - Load: d_we=0, addr 0x40. d_rdata=0xDEADBEEF.
3. Simultaneous if_req and d_req, MEM_LAT=1: d_gnt in cycle 0, d_rvalid in cycle 1, if_gnt in cycle 2, if_rvalid in cycle 3.
4. Fairness, MAX_DATA_BURST=4, d_req and if_req both held high: grant order is D,D,D,D,F,D; burst_cnt=0 after the F grant.
5. MEM_LAT=3: grant in cycle 0, rvalid exactly in cycle 3, busy=1 in cycles 1–3, next grant in cycle 4; no gnt while BUSY even with requests held.
6. Reset mid-transaction: assert reset=0 one cycle after d_gnt with MEM_LAT=3.
   - All outputs are 0 the next cycle; no d_rvalid ever appears for the aborted access.
   - After reset=1, a fresh if_req is granted immediately.
